// File: rtl/pulse_mon_pkg.sv
// Shared types and default constants for the pulse period monitor.
package pulse_mon_pkg;

  localparam int EXP_PERIOD_DEF = 20;
  localparam int CNT_W_DEF      = 6;
  localparam int LOCK_COUNT_DEF = 3;
  localparam int ERRCNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_interval_counter.sv
// Saturating cycles-since-last-pulse counter and interval capture register.
module pulse_interval_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_i,
  input  logic             capture_en_i,
  output logic [CNT_W-1:0] gap_o,
  output logic [CNT_W-1:0] measured_period_o,
  output logic             capture_o
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] period_q;
  logic             capture_q;
  logic [CNT_W-1:0] interval_d;

  // Interval is gap+1; once gap has saturated the interval saturates too.
  assign interval_d = (gap_q == MAX) ? MAX : gap_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q     <= '0;
      period_q  <= '0;
      capture_q <= 1'b0;
    end else begin
      capture_q <= 1'b0;
      if (pulse_i) begin
        gap_q <= '0;
        if (capture_en_i) begin
          period_q  <= interval_d;
          capture_q <= 1'b1;
        end
      end else if (gap_q != MAX) begin
        gap_q <= gap_q + CNT_W'(1);
      end
    end
  end

  assign gap_o             = gap_q;
  assign measured_period_o = period_q;
  assign capture_o         = capture_q;

endmodule

// File: rtl/pulse_period_monitor.sv
// Checks a periodic single-cycle pulse train against EXP_PERIOD, locks, flags errors.
// Optional 8-bit error counter port err_count enabled by PULSE_MON_ERRCNT_EN.
module pulse_period_monitor
  import pulse_mon_pkg::*;
#(
  parameter int EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] measured_period,
  output logic             measured_valid,
  output logic             locked,
  output logic             period_err,
  output logic             missing,
  output state_e           state_dbg
`ifdef PULSE_MON_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  state_e           state_q;
  logic [3:0]       good_cnt_q;
  logic             period_err_q;
  logic             missing_q;
  logic [CNT_W-1:0] gap;
  logic             match;
  logic             perr_d;
  logic             miss_d;

  pulse_interval_counter #(.CNT_W(CNT_W)) u_counter (
    .clk              (clk),
    .rst_n            (rst_n),
    .pulse_i          (pulse_in),
    .capture_en_i     (state_q != IDLE),
    .gap_o            (gap),
    .measured_period_o(measured_period),
    .capture_o        (measured_valid)
  );

  // gap==EXP_PERIOD-1 means this edge completes exactly one expected interval.
  assign match  = (gap == CNT_W'(EXP_PERIOD - 1));
  assign perr_d = pulse_in && (state_q != IDLE) && !match;
  assign miss_d = !pulse_in && (state_q == LOCKED) && match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      good_cnt_q   <= '0;
      period_err_q <= 1'b0;
      missing_q    <= 1'b0;
    end else begin
      period_err_q <= perr_d;
      missing_q    <= miss_d;
      case (state_q)
        IDLE: begin
          if (pulse_in) begin
            state_q    <= ACQUIRE;
            good_cnt_q <= '0;
          end
        end
        ACQUIRE: begin
          if (perr_d) begin
            good_cnt_q <= '0;
          end else if (pulse_in) begin
            if (good_cnt_q + 4'd1 == 4'(LOCK_COUNT)) begin
              state_q    <= LOCKED;
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= good_cnt_q + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (perr_d || miss_d) begin
            state_q    <= ACQUIRE;
            good_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= IDLE;
          good_cnt_q <= '0;
        end
      endcase
    end
  end

  assign locked     = (state_q == LOCKED);
  assign period_err = period_err_q;
  assign missing    = missing_q;
  assign state_dbg  = state_q;

`ifdef PULSE_MON_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if ((perr_d || miss_d) && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERRCNT_W'(1);
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: doc/pulse_period_monitor.md
# pulse_period_monitor

Receive-side checker for a single-cycle periodic pulse train, such as one produced by a countdown pulse generator. It measures the cycle interval between successive pulses and compares it with an expected period. It declares lock after a run of correct intervals and flags early, late and missing pulses. It sits downstream of the pulse source in the same clock domain, and its status outputs feed debug LEDs and the lab self-check logic.

## Interface
- EXP_PERIOD, 20: expected pulse-to-pulse interval in cycles; legal range 2 to 2^CNT_W−2.
- CNT_W, 6: width of the gap counter and of the measured interval.
- LOCK_COUNT, 3: number of consecutive matching intervals required to lock; legal range 1 to 15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- pulse_in  input  1  pulse train, synchronous to clk; each high cycle counts as one pulse.
- measured_period  output  CNT_W  most recent captured interval, saturating.
- measured_valid  output  1  one-cycle strobe: measured_period updated.
- locked  output  1  high while in the LOCKED state.
- period_err  output  1  one-cycle strobe: captured interval ≠ EXP_PERIOD.
- missing  output  1  one-cycle strobe: expected pulse absent while locked.
- err_count  output  8  present only with the macro (see Configuration).

## Operation
- gap counter counts cycles since the last pulse.
  - On an edge with pulse_in=1: capture gap+1 into measured_period, then clear gap to 0.
  - On any other edge: gap increments, saturating at 2^CNT_W−1.
  - measured_period saturates at 2^CNT_W−1.
- A generator pulsing every 20 cycles yields measured_period=20.
- FSM states: IDLE, ACQUIRE, LOCKED. good_cnt is a 4-bit counter of consecutive matching intervals.
  - IDLE + pulse: go to ACQUIRE, gap←0, good_cnt←0. No capture, no measured_valid, no error.
  - ACQUIRE + pulse, interval match: good_cnt+1. If it reaches LOCK_COUNT, go to LOCKED and clear good_cnt.
  - ACQUIRE + pulse, mismatch: period_err, good_cnt←0, stay in ACQUIRE.
  - LOCKED + pulse, match: stay in LOCKED.
  - LOCKED + pulse, mismatch: period_err, go to ACQUIRE, good_cnt←0.
  - LOCKED, no pulse, gap==EXP_PERIOD−1 on this edge: missing, go to ACQUIRE, good_cnt←0. gap keeps counting, so the next pulse is captured as a long interval and produces period_err.
- missing is never raised in IDLE or ACQUIRE.
- A pulse on the same edge where gap==EXP_PERIOD−1 is a match, not a missing event.
- pulse_in held high continuously: every edge captures an interval of 1, giving period_err on every cycle; never locks.
- Every pulse re-anchors gap, including erroneous ones.

## Timing
- All outputs are registered.
  - measured_period, measured_valid, period_err, missing and locked change on the edge that samples the event and are visible in the following cycle.
  - Latency is 1 cycle from the pulse_in sample.
- Strobes last exactly one cycle per event.
- Reset values: state IDLE, gap 0, good_cnt 0, measured_period 0, measured_valid 0, locked 0, period_err 0, missing 0, err_count 0.
- Asserting rst_n low mid-operation clears everything immediately (asynchronously). The first pulse after release behaves as in IDLE.
- Minimum lock time from the first pulse: LOCK_COUNT×EXP_PERIOD cycles, plus 1 cycle of output latency.

## Configuration
- PULSE_MON_ERRCNT_EN defined:
  - err_count exists, an 8-bit saturating count of period_err and missing events.
  - It increments on the same edge as the strobe and saturates at 255.
  - It is cleared only by reset.
- PULSE_MON_ERRCNT_EN undefined:
  - The err_count port and its register are absent.
  - All other behaviour is identical.

## Structure
- Shared package pulse_mon_pkg holds:
  - the state typedef enum {IDLE, ACQUIRE, LOCKED};
  - default constants for EXP_PERIOD, CNT_W and LOCK_COUNT;
  - ERRCNT_W=8.
- One sub-module, pulse_interval_counter. It contains the saturating gap counter and the capture register. It outputs gap, measured_period and a capture strobe.
- The FSM, the good_cnt counter and error generation live in the top module.

## Test plan
- Generator-style pulses every 20 cycles from reset release -> measured_period=20 each interval, period_err never set, locked rises 1 cycle after the 3rd matching capture.
- Locked, then one pulse arrives after 17 cycles -> period_err single strobe with measured_period=17, locked falls, relock after 3 further 20-cycle intervals.
- Locked, then one pulse omitted -> missing strobe 1 cycle after gap reaches 19. The next pulse yields measured_period=40 plus period_err.
- pulse_in held high for 10 cycles after the first pulse -> 10 period_err strobes with measured_period=1, locked stays 0. With the macro defined, err_count=10.
- Pulses 100 cycles apart -> measured_period saturates at 63 plus period_err. Separately, assert rst_n mid-LOCKED -> all outputs 0 at once and the FSM returns to IDLE.
